wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile.sv | 99 +++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Write-back register file: 8 x 16-bit registers with a single commit port,
// two combinational read ports with same-cycle write bypass, a zero-latency
// forwarding tap, and registered retire statistics.
module wb_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_reg_write_wb,
  input  logic        op_reg_write_address_wb,
  input  logic        op_res_wb,
  input  logic [2:0]  rs_wb,
  input  logic [2:0]  rd_wb,
  input  logic [15:0] data_register_wb,
  input  logic [15:0] memory_data_register_wb,
  input  logic [2:0]  ra_id,
  input  logic [2:0]  rb_id,
  output logic [15:0] read_data_a,
  output logic [15:0] read_data_b,
  output logic        fwd_valid,
  output logic [2:0]  fwd_address,
  output logic [15:0] fwd_data,
  output logic [15:0] retire_count,
  output logic [2:0]  last_address,
  output logic [15:0] last_data
);

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] count_q, count_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0] last_data_q, last_data_d;

  logic [DW-1:0] wdata;
  logic [AW-1:0] waddr;
  logic          commit;

  // Write-back source selection; reset masks the commit so it also kills bypass.
  always_comb begin
    wdata  = op_res_wb ? memory_data_register_wb : data_register_wb;
    waddr  = op_reg_write_address_wb ? rs_wb : rd_wb;
    commit = op_reg_write_wb & ~reset;
  end

  // Next-state: registers and statistics move only on a commit.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      regs_d[i] = regs_q[i];
    end
    count_d     = count_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    if (commit) begin
      regs_d[waddr] = wdata;
      count_d       = count_q + DW'(1);
      last_addr_d   = waddr;
      last_data_d   = wdata;
    end
  end

  // State register with synchronous reset taking priority over a commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      count_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= regs_d[i];
      end
      count_q     <= count_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
    end
  end

  // Read ports bypass the in-flight write so decode never sees a stale value.
  always_comb begin
    read_data_a = (commit && (ra_id == waddr)) ? wdata : regs_q[ra_id];
    read_data_b = (commit && (rb_id == waddr)) ? wdata : regs_q[rb_id];
  end

  // Forwarding tap mirrors the write being committed this cycle.
  always_comb begin
    fwd_valid   = commit;
    fwd_address = waddr;
    fwd_data    = wdata;
  end

  assign retire_count = count_q;
  assign last_address = last_addr_q;
  assign last_data    = last_data_q;

endmodule
